axi_mem_bridge: RTL

// AXI4 slave that terminates the core's 64-bit AXI memory master (io_axi_mem_* bundle) onto a

---
 rtl/axi_mem_bridge.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_bridge.sv
// AXI4 slave bridging a 64-bit memory master onto a 1-cycle-latency single-port SRAM.
// Optional AXI_MEM_BRIDGE_ATOP_ERR_EN: atomic writes (awatop != 0) are answered SLVERR, unwritten.
module axi_mem_bridge #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned MEM_AW    = 16,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ID_WIDTH-1:0] s_awid,
    input  logic [63:0]         s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awlock,
    input  logic [3:0]          s_awcache,
    input  logic [2:0]          s_awprot,
    input  logic [3:0]          s_awqos,
    input  logic [3:0]          s_awregion,
    input  logic                s_awuser,
    input  logic [5:0]          s_awatop,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [63:0]         s_wdata,
    input  logic [7:0]          s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wuser,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_WIDTH-1:0] s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_buser,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_WIDTH-1:0] s_arid,
    input  logic [63:0]         s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arlock,
    input  logic [3:0]          s_arcache,
    input  logic [2:0]          s_arprot,
    input  logic [3:0]          s_arqos,
    input  logic [3:0]          s_arregion,
    input  logic                s_aruser,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_WIDTH-1:0] s_rid,
    output logic [63:0]         s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_ruser,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [MEM_AW-1:0]   mem_addr_o,
    output logic [63:0]         mem_wdata_o,
    output logic [7:0]          mem_be_o,
    input  logic [63:0]         mem_rdata_i
);

    localparam logic [63:0] MemEnd = BASE_ADDR + (64'd8 << MEM_AW);
    localparam logic [1:0]  RespOkay = 2'b00;
    localparam logic [1:0]  RespSlv  = 2'b10;
    localparam logic [1:0]  RespDec  = 2'b11;

    typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StRdData, StWrData, StWrResp} state_e;

    state_e              state_q, state_d;
    logic                prio_q, prio_d;  // 0: write side wins a tie
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [63:0]         addr_q, addr_d;
    logic [7:0]          len_q, len_d, cnt_q, cnt_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic                over_q, over_d, slv_q, slv_d, dec_q, dec_d, atop_q, atop_d, rd_ok_q, rd_ok_d;
    logic [63:0]         rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;

    logic [63:0] beat_addr, offset;
    logic        in_range, burst_err, aw_sel, ar_sel, atop_in;

    assign burst_err = burst_q[1];
    assign beat_addr = (burst_q == 2'b00) ? addr_q : addr_q + (64'(cnt_q) << size_q);
    assign in_range  = (beat_addr >= BASE_ADDR) && (beat_addr < MemEnd);
    assign offset    = beat_addr - BASE_ADDR;
    assign aw_sel    = s_awvalid && (!s_arvalid || !prio_q);
    assign ar_sel    = s_arvalid && (!s_awvalid || prio_q);

`ifdef AXI_MEM_BRIDGE_ATOP_ERR_EN
    assign atop_in = (s_awatop != 6'd0);
`else
    assign atop_in = 1'b0;
`endif

    logic unused_sigs;
    assign unused_sigs = ^{s_awlock, s_awcache, s_awprot, s_awqos, s_awregion, s_awuser, s_wuser,
                           s_arlock, s_arcache, s_arprot, s_arqos, s_arregion, s_aruser, s_awatop,
                           offset[63:MEM_AW+3], offset[2:0]};

    assign mem_addr_o  = offset[MEM_AW+2:3];
    assign mem_wdata_o = s_wdata;
    assign mem_be_o    = s_wstrb;
    assign s_bid       = id_q;
    assign s_rid       = id_q;
    assign s_rdata     = rdata_q;
    assign s_rresp     = rresp_q;
    assign s_buser     = 1'b0;
    assign s_ruser     = 1'b0;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        over_d    = over_q;
        slv_d     = slv_q;
        dec_d     = dec_q;
        atop_d    = atop_q;
        rd_ok_d   = rd_ok_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        s_awready = 1'b0;
        s_arready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = RespOkay;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                s_awready = aw_sel;
                s_arready = ar_sel;
                cnt_d     = 8'd0;
                over_d    = 1'b0;
                slv_d     = 1'b0;
                dec_d     = 1'b0;
                if (aw_sel) begin
                    id_d    = s_awid;
                    addr_d  = s_awaddr;
                    len_d   = s_awlen;
                    size_d  = s_awsize;
                    burst_d = s_awburst;
                    atop_d  = atop_in;
                    prio_d  = !prio_q;
                    state_d = StWrData;
                end else if (ar_sel) begin
                    id_d    = s_arid;
                    addr_d  = s_araddr;
                    len_d   = s_arlen;
                    size_d  = s_arsize;
                    burst_d = s_arburst;
                    atop_d  = 1'b0;
                    prio_d  = !prio_q;
                    state_d = StRdReq;
                end
            end
            StRdReq: begin
                mem_req_o = in_range && !burst_err;
                rd_ok_d   = in_range && !burst_err;
                rresp_d   = burst_err ? RespSlv : (!in_range ? RespDec : RespOkay);
                state_d   = StRdWait;
            end
            StRdWait: begin
                rdata_d = rd_ok_q ? mem_rdata_i : 64'd0;
                state_d = StRdData;
            end
            StRdData: begin
                s_rvalid = 1'b1;
                s_rlast  = (cnt_q == len_q);
                if (s_rready) begin
                    if (cnt_q == len_q) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StRdReq;
                    end
                end
            end
            StWrData: begin
                s_wready = 1'b1;
                if (s_wvalid) begin
                    mem_req_o = in_range && !burst_err && !atop_q && !over_q;
                    mem_we_o  = 1'b1;
                    if (!over_q && !in_range) dec_d = 1'b1;
                    if (s_wlast) begin
                        if (!over_q && cnt_q != len_q) slv_d = 1'b1;
                        state_d = StWrResp;
                    end else if (cnt_q == len_q) begin
                        // Beats past awlen are swallowed until wlast shows up.
                        over_d = 1'b1;
                        slv_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StWrResp: begin
                s_bvalid = 1'b1;
                s_bresp  = dec_q ? RespDec : ((slv_q || burst_err || atop_q) ? RespSlv : RespOkay);
                if (s_bready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            id_q    <= '0;
            addr_q  <= 64'd0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'b00;
            cnt_q   <= 8'd0;
            over_q  <= 1'b0;
            slv_q   <= 1'b0;
            dec_q   <= 1'b0;
            atop_q  <= 1'b0;
            rd_ok_q <= 1'b0;
            rdata_q <= 64'd0;
            rresp_q <= RespOkay;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            over_q  <= over_d;
            slv_q   <= slv_d;
            dec_q   <= dec_d;
            atop_q  <= atop_d;
            rd_ok_q <= rd_ok_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

endmodule
